// File: rtl/pca_fit_pkg.sv
// Shared types for the track hit collector: geometry constants, hit triple and read-FSM states.
package pca_fit_pkg;

    localparam int NLAYERS = 6;
    localparam int COORD_W = 8;

    typedef logic [2:0] layer_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } hit_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_BURST = 2'd1,
        RD_GAP   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/hit_bank.sv
// One track buffer: NLAYERS hit triples plus a per-layer fill mask.
// Write port is synchronous; read port is combinational.
module hit_bank
    import pca_fit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en_i,
    input  layer_t             wr_layer_i,
    input  hit_t               wr_data_i,
    input  logic               mask_clr_i,
    output logic [NLAYERS-1:0] mask_o,
    input  layer_t             rd_idx_i,
    output hit_t               rd_data_o
);

    hit_t               entry [NLAYERS];
    logic [NLAYERS-1:0] mask_q;

    // Clear wins over set so an eot hit leaves the mask empty for the next track.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
        end else if (mask_clr_i) begin
            mask_q <= '0;
        end else if (wr_en_i) begin
            mask_q[wr_layer_i] <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NLAYERS; gi++) begin : g_entry
        hit_t entry_q;

        always_ff @(posedge clk) begin
            if (wr_en_i && (wr_layer_i == layer_t'(gi))) begin
                entry_q <= wr_data_i;
            end
        end

        assign entry[gi] = entry_q;
    end

    assign mask_o    = mask_q;
    assign rd_data_o = entry[rd_idx_i];

endmodule

// File: rtl/track_hit_collector.sv
// Assembles per-layer hits into complete tracks in a ping-pong pair of banks and
// streams each finished track to the fitter as one contiguous NLAYERS-beat burst.
module track_hit_collector
    import pca_fit_pkg::*;
#(
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic [2:0]         hit_layer,
    input  logic [COORD_W-1:0] hit_x,
    input  logic [COORD_W-1:0] hit_y,
    input  logic [COORD_W-1:0] hit_z,
    input  logic               hit_eot,
    output logic               dv_out_0,
    output logic [COORD_W-1:0] data_out_x_0,
    output logic [COORD_W-1:0] data_out_y_0,
    output logic [COORD_W-1:0] data_out_z_0,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   bad_layer_cnt,
    output logic [CNT_W-1:0]   dup_cnt
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    logic                    wr_bank_q, wr_bank_d;
    logic                    rd_bank_q;
    logic [1:0]              full_q, full_d;
    rd_state_e               state_q;
    layer_t                  idx_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    dv_q;
    hit_t                    out_q;
    logic [CNT_W-1:0]        drop_q, bad_q, dup_q;

    logic                    xfer, legal, dup_hit, complete, dropped, last_beat, bypass;
    logic [NLAYERS-1:0]      hit_onehot, cur_mask, new_mask;
    logic [1:0][NLAYERS-1:0] bank_mask;
    hit_t [1:0]              bank_rd;
    hit_t                    hit_in, rd_data;
    layer_t                  rd_idx;

    assign hit_ready = reset & ~full_q[wr_bank_q];
    assign xfer      = hit_valid & hit_ready;
    assign legal     = int'(hit_layer) < NLAYERS;
    assign hit_in    = '{x: hit_x, y: hit_y, z: hit_z};

    always_comb begin
        hit_onehot = '0;
        if (legal) begin
            hit_onehot[hit_layer] = 1'b1;
        end
    end

    assign cur_mask = bank_mask[wr_bank_q];
    assign new_mask = cur_mask | hit_onehot;
    assign dup_hit  = xfer & |(cur_mask & hit_onehot);
    assign complete = xfer & hit_eot & (&new_mask);
    assign dropped  = xfer & hit_eot & ~(&new_mask);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        hit_bank u_bank (
            .clk        (clk),
            .reset      (reset),
            .wr_en_i    (xfer & legal & (wr_bank_q == 1'(gi))),
            .wr_layer_i (hit_layer),
            .wr_data_i  (hit_in),
            .mask_clr_i (xfer & hit_eot & (wr_bank_q == 1'(gi))),
            .mask_o     (bank_mask[gi]),
            .rd_idx_i   (rd_idx),
            .rd_data_o  (bank_rd[gi])
        );
    end

    // Beat 0 can launch in the same cycle the eot hit lands, so forward that hit past the bank.
    assign rd_idx    = (state_q == RD_BURST) ? idx_q : '0;
    assign bypass    = xfer & legal & (wr_bank_q == rd_bank_q) & (hit_layer == rd_idx);
    assign rd_data   = bypass ? hit_in : bank_rd[rd_bank_q];
    assign last_beat = (state_q == RD_BURST) && (idx_q == layer_t'(NLAYERS - 1));

    always_comb begin
        full_d = full_q;
        if (last_beat) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
        end
        wr_bank_d = complete ? ~wr_bank_q : wr_bank_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            drop_q    <= '0;
            bad_q     <= '0;
            dup_q     <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            if (dropped && (drop_q != '1)) drop_q <= drop_q + 1'b1;
            if (xfer && !legal && (bad_q != '1)) bad_q <= bad_q + 1'b1;
            if (dup_hit && (dup_q != '1)) dup_q <= dup_q + 1'b1;
        end
    end

    // Read FSM: IDLE emits beat 0 itself, BURST emits beats 1..NLAYERS-1, GAP idles the link.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RD_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            dv_q      <= 1'b0;
            out_q     <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (full_d[rd_bank_q]) begin
                        dv_q    <= 1'b1;
                        out_q   <= rd_data;
                        idx_q   <= layer_t'(1);
                        state_q <= RD_BURST;
                    end else begin
                        dv_q <= 1'b0;
                    end
                end
                RD_BURST: begin
                    dv_q  <= 1'b1;
                    out_q <= rd_data;
                    if (last_beat) begin
                        rd_bank_q <= ~rd_bank_q;
                        idx_q     <= '0;
                        gap_q     <= '0;
                        state_q   <= (GAP == 0) ? RD_IDLE : RD_GAP;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                RD_GAP: begin
                    dv_q <= 1'b0;
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        state_q <= RD_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    dv_q    <= 1'b0;
                    state_q <= RD_IDLE;
                end
            endcase
        end
    end

    assign dv_out_0      = dv_q;
    assign data_out_x_0  = out_q.x;
    assign data_out_y_0  = out_q.y;
    assign data_out_z_0  = out_q.z;
    assign drop_cnt      = drop_q;
    assign bad_layer_cnt = bad_q;
    assign dup_cnt       = dup_q;

endmodule

// File: tb/tb_track_hit_collector.sv
// Bench for track_hit_collector: directed table of tracks, back-to-back and reset corners,
// then random tracks checked against a per-track reference model.
module tb_track_hit_collector;

    localparam int NL   = 6;
    localparam int GAPC = 2;
    localparam int NCASE = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hit_valid = 1'b0;
    logic       hit_eot = 1'b0;
    logic [2:0] hit_layer = 3'd0;
    logic [7:0] hit_x = 8'd0, hit_y = 8'd0, hit_z = 8'd0;
    logic       hit_ready, dv_out_0;
    logic [7:0] data_out_x_0, data_out_y_0, data_out_z_0;
    logic [7:0] drop_cnt, bad_layer_cnt, dup_cnt;

    always #5 clk = ~clk;

    track_hit_collector #(.GAP(GAPC), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .hit_valid     (hit_valid),
        .hit_ready     (hit_ready),
        .hit_layer     (hit_layer),
        .hit_x         (hit_x),
        .hit_y         (hit_y),
        .hit_z         (hit_z),
        .hit_eot       (hit_eot),
        .dv_out_0      (dv_out_0),
        .data_out_x_0  (data_out_x_0),
        .data_out_y_0  (data_out_y_0),
        .data_out_z_0  (data_out_z_0),
        .drop_cnt      (drop_cnt),
        .bad_layer_cnt (bad_layer_cnt),
        .dup_cnt       (dup_cnt)
    );

    typedef struct { int cyc; logic [7:0] x; logic [7:0] y; logic [7:0] z; } beat_t;
    typedef struct { logic [7:0] x; logic [7:0] y; logic [7:0] z; } trip_t;
    typedef struct {
        int n;
        int lay [8];
        int xv  [8];
        int nb;
        int ex  [6];
        int d_drop;
        int d_dup;
        int d_bad;
    } case_t;

    beat_t beats [$];
    trip_t exp_q [$];
    int    cyc = 0;
    int    rd_ptr = 0;
    int    n_vec = 0, n_fail = 0;
    int    exp_drop = 0, exp_dup = 0, exp_bad = 0;
    bit    m_mask [NL];
    trip_t m_data [NL];
    bit    saw_block = 1'b0;
    case_t tbl [NCASE];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv_out_0) beats.push_back('{cyc, data_out_x_0, data_out_y_0, data_out_z_0});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] fy(input logic [7:0] x);
        return x ^ 8'h5A;
    endfunction

    function automatic logic [7:0] fz(input logic [7:0] x);
        return x + 8'd100;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Called on a falling edge; returns the cycle number in which the hit transferred.
    task automatic send_hit(input int lay, input logic [7:0] x, input logic e, output int acc);
        int w;
        w = 0;
        hit_valid = 1'b1;
        hit_layer = 3'(lay);
        hit_x     = x;
        hit_y     = fy(x);
        hit_z     = fz(x);
        hit_eot   = e;
        if (!hit_ready) saw_block = 1'b1;
        while (!hit_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        acc = cyc;
        if (!hit_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL hit_accept: hit_ready low for %0d cycles, expected 1", w);
        end
        @(negedge clk);
        hit_valid = 1'b0;
        hit_eot   = 1'b0;
    endtask

    // Reference: a track is emitted iff every layer was seen before/at its eot hit.
    task automatic model_hit(input int lay, input logic [7:0] x, input logic e);
        bit all1;
        if (lay < NL) begin
            if (m_mask[lay]) exp_dup = sat(exp_dup + 1);
            m_mask[lay] = 1'b1;
            m_data[lay] = '{x, fy(x), fz(x)};
        end else begin
            exp_bad = sat(exp_bad + 1);
        end
        if (e) begin
            all1 = 1'b1;
            for (int k = 0; k < NL; k++) all1 &= m_mask[k];
            if (all1) begin
                for (int k = 0; k < NL; k++) exp_q.push_back(m_data[k]);
            end else begin
                exp_drop = sat(exp_drop + 1);
            end
            for (int k = 0; k < NL; k++) m_mask[k] = 1'b0;
        end
    endtask

    task automatic hit_m(input int lay, input logic [7:0] x, input logic e);
        int acc;
        send_hit(lay, x, e, acc);
        model_hit(lay, x, e);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_drop_cnt"}, int'(drop_cnt), exp_drop);
        check({tag, "_dup_cnt"}, int'(dup_cnt), exp_dup);
        check({tag, "_bad_layer_cnt"}, int'(bad_layer_cnt), exp_bad);
    endtask

    // Wait for all expected beats, then compare data, burst contiguity and inter-burst gaps.
    task automatic drain_check(input bit exact_gap);
        int w, n, g;
        beat_t b;
        trip_t e;
        w = 0;
        while ((beats.size() - rd_ptr) < exp_q.size() && w < 3000) begin
            @(negedge clk);
            w++;
        end
        repeat (12) @(negedge clk);
        check("beat_count", beats.size() - rd_ptr, exp_q.size());
        n = beats.size() - rd_ptr;
        if (n > exp_q.size()) n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            b = beats[rd_ptr + i];
            e = exp_q[i];
            n_vec++;
            if (b.x !== e.x || b.y !== e.y || b.z !== e.z) begin
                n_fail++;
                $display("FAIL beat[%0d]: got x=%0d y=%0d z=%0d, expected x=%0d y=%0d z=%0d",
                         i, b.x, b.y, b.z, e.x, e.y, e.z);
            end
            if ((i % NL) != 0) begin
                check("burst_contiguous", b.cyc - beats[rd_ptr + i - 1].cyc, 1);
            end else if (i > 0) begin
                g = b.cyc - beats[rd_ptr + i - 1].cyc - 1;
                if (exact_gap) check("burst_gap", g, GAPC);
                else check("burst_gap_min", int'(g >= GAPC), 1);
            end
        end
        rd_ptr = beats.size();
        exp_q.delete();
    endtask

    initial begin
        int acc, eot_cyc, p0, nb, w, p;
        int perm [6];
        int lays [8];
        int nh, miss, j, tmp, pos;

        tbl[0].n = 6; tbl[0].lay = '{0, 1, 2, 3, 4, 5, 0, 0}; tbl[0].xv = '{1, 2, 3, 4, 5, 6, 0, 0};
        tbl[0].nb = 1; tbl[0].ex = '{1, 2, 3, 4, 5, 6}; tbl[0].d_drop = 0; tbl[0].d_dup = 0; tbl[0].d_bad = 0;
        tbl[1].n = 6; tbl[1].lay = '{5, 3, 1, 0, 2, 4, 0, 0}; tbl[1].xv = '{15, 13, 11, 10, 12, 14, 0, 0};
        tbl[1].nb = 1; tbl[1].ex = '{10, 11, 12, 13, 14, 15}; tbl[1].d_drop = 0; tbl[1].d_dup = 0; tbl[1].d_bad = 0;
        tbl[2].n = 5; tbl[2].lay = '{0, 1, 2, 3, 4, 0, 0, 0}; tbl[2].xv = '{40, 41, 42, 43, 44, 0, 0, 0};
        tbl[2].nb = 0; tbl[2].ex = '{0, 0, 0, 0, 0, 0}; tbl[2].d_drop = 1; tbl[2].d_dup = 0; tbl[2].d_bad = 0;
        tbl[3].n = 6; tbl[3].lay = '{0, 1, 2, 3, 4, 5, 0, 0}; tbl[3].xv = '{20, 21, 22, 23, 24, 25, 0, 0};
        tbl[3].nb = 1; tbl[3].ex = '{20, 21, 22, 23, 24, 25}; tbl[3].d_drop = 0; tbl[3].d_dup = 0; tbl[3].d_bad = 0;
        tbl[4].n = 8; tbl[4].lay = '{2, 2, 7, 0, 1, 3, 4, 5}; tbl[4].xv = '{7, 9, 99, 30, 31, 33, 34, 35};
        tbl[4].nb = 1; tbl[4].ex = '{30, 31, 9, 33, 34, 35}; tbl[4].d_drop = 0; tbl[4].d_dup = 1; tbl[4].d_bad = 1;
        tbl[5].n = 7; tbl[5].lay = '{0, 1, 2, 3, 4, 5, 6, 0}; tbl[5].xv = '{50, 51, 52, 53, 54, 55, 66, 0};
        tbl[5].nb = 1; tbl[5].ex = '{50, 51, 52, 53, 54, 55}; tbl[5].d_drop = 0; tbl[5].d_dup = 0; tbl[5].d_bad = 1;
        tbl[6].n = 7; tbl[6].lay = '{0, 1, 2, 3, 4, 5, 0, 0}; tbl[6].xv = '{60, 61, 62, 63, 64, 65, 77, 0};
        tbl[6].nb = 1; tbl[6].ex = '{77, 61, 62, 63, 64, 65}; tbl[6].d_drop = 0; tbl[6].d_dup = 1; tbl[6].d_bad = 0;

        for (int k = 0; k < NL; k++) m_mask[k] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_hit_ready", int'(hit_ready), 0);
        check("rst_dv_out", int'(dv_out_0), 0);
        check("rst_data_x", int'(data_out_x_0), 0);
        check_counters("rst");
        reset = 1'b1;
        #1;
        check("post_rst_hit_ready", int'(hit_ready), 1);
        @(negedge clk);

        // Directed table
        for (int c = 0; c < NCASE; c++) begin
            eot_cyc = 0;
            for (int h = 0; h < tbl[c].n; h++) begin
                send_hit(tbl[c].lay[h], 8'(tbl[c].xv[h]), logic'(h == tbl[c].n - 1), acc);
                eot_cyc = acc;
            end
            if (tbl[c].nb != 0) begin
                for (int k = 0; k < NL; k++) begin
                    exp_q.push_back('{8'(tbl[c].ex[k]), fy(8'(tbl[c].ex[k])), fz(8'(tbl[c].ex[k]))});
                end
            end
            exp_drop += tbl[c].d_drop;
            exp_dup  += tbl[c].d_dup;
            exp_bad  += tbl[c].d_bad;
            p0 = rd_ptr;
            drain_check(1'b0);
            if (tbl[c].nb != 0 && beats.size() > p0) check("eot_to_dv_latency", beats[p0].cyc - eot_cyc, 1);
            check_counters($sformatf("case%0d", c));
            $display("case %0d: %0d hits sent, %0d beats seen", c, tbl[c].n, beats.size() - p0);
        end

        // Four back-to-back tracks: writer outruns reader and must be stalled, gaps are minimal
        saw_block = 1'b0;
        for (int t = 0; t < 4; t++) begin
            for (int l = 0; l < NL; l++) hit_m(l, 8'($urandom), logic'(l == NL - 1));
        end
        check("b2b_ready_dropped", int'(saw_block), 1);
        drain_check(1'b1);
        check_counters("b2b");
        $display("back-to-back: 4 tracks sent");

        // Random tracks: shuffled layers, occasional missing layer, extra dup/illegal hits, idle gaps
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < NL; k++) perm[k] = k;
            for (int k = NL - 1; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = perm[k]; perm[k] = perm[j]; perm[j] = tmp;
            end
            miss = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NL - 1)) : -1;
            nh = 0;
            for (int k = 0; k < NL; k++) begin
                if (perm[k] != miss) begin
                    lays[nh] = perm[k];
                    nh++;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                pos = $urandom_range(0, nh);
                for (int k = nh; k > pos; k--) lays[k] = lays[k - 1];
                lays[pos] = $urandom_range(0, 7);
                nh++;
            end
            for (int h = 0; h < nh; h++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                hit_m(lays[h], 8'($urandom), logic'(h == nh - 1));
            end
        end
        drain_check(1'b0);
        check_counters("random");
        $display("random: 40 tracks sent");

        // Saturation of the bad-layer counter
        for (int i = 0; i < 300; i++) hit_m(6 + (i % 2), 8'(i), 1'b0);
        repeat (2) @(negedge clk);
        check("bad_layer_saturated", int'(bad_layer_cnt), 255);
        check_counters("saturate");
        $display("saturation: 300 illegal hits sent");

        // Reset in the middle of a burst (beat index 3)
        for (int l = 0; l < NL; l++) send_hit(l, 8'(l + 1), logic'(l == NL - 1), acc);
        nb = 0;
        w = 0;
        while (nb < 4 && w < 100) begin
            if (dv_out_0) nb++;
            if (nb < 4) begin
                @(negedge clk);
                w++;
            end
        end
        check("reset_beat3_reached", nb, 4);
        #1 reset = 1'b0;
        #1;
        check("midburst_rst_dv", int'(dv_out_0), 0);
        check("midburst_rst_data_x", int'(data_out_x_0), 0);
        p = beats.size();
        repeat (3) @(negedge clk);
        check("in_rst_hit_ready", int'(hit_ready), 0);
        reset = 1'b1;
        #1;
        check("rel_hit_ready", int'(hit_ready), 1);
        repeat (20) @(negedge clk);
        check("no_residual_burst", beats.size() - p, 0);
        for (int k = 0; k < NL; k++) m_mask[k] = 1'b0;
        exp_drop = 0;
        exp_dup  = 0;
        exp_bad  = 0;
        exp_q.delete();
        check_counters("after_rst");
        rd_ptr = beats.size();
        for (int l = 0; l < NL; l++) hit_m(l, 8'(l + 200), logic'(l == NL - 1));
        drain_check(1'b0);
        $display("reset: mid-burst reset and recovery track done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
